// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, redirect-source encoding, and a
// helper for sizing occupancy counters.
package cpu_pkg;

  localparam int ADDR_W  = 19;
  localparam int INSTR_W = 32;

  // Control-flow redirect source, as reported by decode.
  typedef enum logic [1:0] {
    REDIR_BRANCH = 2'd0,
    REDIR_JUMP   = 2'd1,
    REDIR_CALL   = 2'd2,
    REDIR_RET    = 2'd3
  } redir_src_e;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               rd_q, wr_q;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  // Flush wins over everything. A push into a full FIFO is only taken
  // when a pop frees a slot in the same cycle.
  assign do_pop  = pop && (cnt_q != '0) && !flush;
  assign do_push = push && !flush && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It issues reads at pc, advances the PC on a
// grant, and queues returned instructions with their addresses for decode.
// A redirect flushes the buffer and arranges for in-flight reads to be
// dropped when they return.
module fetch_unit #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int INSTR_W   = cpu_pkg::INSTR_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redirect,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  import cpu_pkg::*;

  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int EW = ADDR_W + INSTR_W;

  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     aq_count, buf_count;
  logic [ADDR_W-1:0] aq_head;
  logic [EW-1:0]     buf_head;
  logic [CW:0]       credit_used;
  logic              fire, rsp, keep, pop;

  // Credits: every slot is either holding an instruction or reserved for a
  // read in flight, so a response can never find the buffer full.
  assign credit_used = {1'b0, out_q} + {1'b0, buf_count};
  assign imem_req    = !reset && !redirect && (credit_used < (CW+1)'(BUF_DEPTH));
  assign fire        = imem_req && imem_gnt;
  assign imem_addr   = pc;
  assign pc_next     = fire ? pc + ADDR_W'(1) : pc;

  // A response only counts when a read is known to be outstanding; this
  // ignores anything arriving for reads issued before a reset.
  assign rsp  = imem_rvalid && (aq_count != '0);
  assign keep = rsp && !redirect && (drop_q == '0);

  assign instr_valid = (buf_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_pc    = buf_head[EW-1:INSTR_W];
  assign instr       = buf_head[INSTR_W-1:0];

  // After a redirect, every read still in flight is stale.
  always_comb begin
    out_d  = out_q + CW'(fire) - CW'(rsp);
    drop_d = drop_q;
    if (redirect)                  drop_d = out_q - CW'(rsp);
    else if (rsp && drop_q != '0)  drop_d = drop_q - CW'(1);
  end

  // Outstanding-read and drop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  // Addresses of granted reads, popped in order as responses return.
  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(BUF_DEPTH)) u_addr_q (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (pc),
    .pop       (rsp),
    .flush     (1'b0),
    .count     (aq_count),
    .head      (aq_head)
  );

  // Instruction buffer feeding decode; the flush also discards a same-cycle pop.
  fetch_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data ({aq_head, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .count     (buf_count),
    .head      (buf_head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit. It contains an in-order memory model
// and a reference model that tracks in-flight reads, with a stale flag,
// and the expected decode queue.
module tb_fetch_unit;

  localparam int AW    = 19;
  localparam int IW    = 32;
  localparam int DEPTH = 2;

  typedef struct { logic [AW-1:0] addr; bit stale; }          infl_t;
  typedef struct { logic [AW-1:0] addr; logic [IW-1:0] data; } ent_t;
  typedef struct { logic [AW-1:0] addr; int due; }             mreq_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] pc_next;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .BUF_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .redirect    (redirect),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  bit    after_rst = 1'b0;
  infl_t infl[$];
  ent_t  ebuf[$];
  mreq_t memq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the models.
  task automatic step(input bit rst, input bit rd, input logic [AW-1:0] tgt,
                      input bit rdy, input bit gnt, input int lat);
    infl_t         f;
    logic [AW-1:0] pcn;
    bit            ereq, efire, hv;
    reset       = rst;
    redirect    = rd;
    instr_ready = rdy;
    imem_gnt    = gnt;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!rst && memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = {13'h0, memq[0].addr};
      void'(memq.pop_front());
    end
    #2;
    ereq  = !rst && !rd && (infl.size() + ebuf.size() < DEPTH);
    efire = ereq && gnt;
    pcn   = efire ? pc + 19'd1 : pc;
    hv    = (ebuf.size() != 0);
    chk("imem_addr", 64'(imem_addr), 64'(pc));
    chk("imem_req", 64'(imem_req), 64'(ereq));
    chk("pc_next", 64'(pc_next), 64'(pcn));
    chk("instr_valid", 64'(instr_valid), 64'(hv));
    if (hv) begin
      chk("instr_pc", 64'(instr_pc), 64'(ebuf[0].addr));
      chk("instr", 64'(instr), 64'(ebuf[0].data));
    end
    if (after_rst) begin
      chk("rst_instr", 64'(instr), 64'(0));
      chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    end
    // The memory serves whatever the DUT actually requested.
    if (imem_req && gnt) memq.push_back('{addr: pc, due: cyc + lat});
    if (rst) begin
      infl.delete();
      ebuf.delete();
      memq.delete();
    end else begin
      if (hv && rdy && !rd) void'(ebuf.pop_front());
      if (imem_rvalid && infl.size() != 0) begin
        f = infl.pop_front();
        if (!f.stale && !rd) ebuf.push_back('{addr: f.addr, data: imem_rdata});
      end
      if (rd) begin
        ebuf.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
      end
      if (efire) infl.push_back('{addr: pc, stale: 1'b0});
    end
    after_rst = rst;
    @(posedge clk);
    #1;
    pc = rst ? '0 : (rd ? tgt : pcn);
    cyc++;
  endtask

  // ev_kind: 0 none, 1 redirect to ev_tgt, 2 one-cycle reset, 3 ready low 6 cycles.
  task automatic run_phase(input int len, input int lat, input int gp, input int rp,
                           input int dp, input logic [AW-1:0] start,
                           input int ev_at, input int ev_kind, input logic [AW-1:0] ev_tgt);
    for (int c = 0; c < len; c++) begin
      bit            rst, rd, rdy, gnt;
      logic [AW-1:0] tgt;
      rst = 1'b0;
      rd  = ($urandom_range(99) < dp);
      tgt = AW'($urandom);
      rdy = ($urandom_range(99) < rp);
      gnt = ($urandom_range(99) < gp);
      if (c == 0) begin
        rd  = 1'b1;
        tgt = start;
      end
      if (c == ev_at) begin
        case (ev_kind)
          1: begin rd = 1'b1; tgt = ev_tgt; end
          2: begin rst = 1'b1; rd = 1'b0; end
          default: ;
        endcase
      end
      if (ev_kind == 3 && c >= ev_at && c < ev_at + 6) rdy = 1'b0;
      step(rst, rd, tgt, rdy, gnt, lat);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    // Streaming from 0x10 with 1-cycle memory.
    run_phase(30, 1, 100, 100, 0, 19'h00010, -1, 0, '0);
    // Backpressure: decode stalls for 6 cycles.
    run_phase(30, 1, 100, 100, 0, 19'h00040, 5, 3, '0);
    // Redirect at pc 0x20 with two reads in flight on 3-cycle memory.
    run_phase(20, 3, 100, 100, 0, 19'h0001E, 3, 1, 19'h00100);
    // PC wrap.
    run_phase(20, 1, 100, 100, 0, 19'h7FFFD, -1, 0, '0);
    // Reset mid-operation with reads outstanding.
    run_phase(25, 3, 100, 50, 0, 19'h00200, 3, 2, '0);
    // Redirect landing on a response and a pop.
    run_phase(20, 1, 100, 100, 0, 19'h00300, 4, 1, 19'h00400);
    run_phase(20, 2, 100, 100, 0, 19'h00500, 5, 1, 19'h00600);
    // Random mixes with frequent redirects and one reset each.
    for (int p = 0; p < 6; p++)
      run_phase(400, $urandom_range(1, 4), $urandom_range(50, 100), $urandom_range(30, 100),
                8, AW'($urandom), $urandom_range(50, 350), 2, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
